// File: rtl/xram_resp.sv
// Byte-wide XRAM target: stb/wr/ack handshake with WAIT_CYCLES wait states and a one-cycle ack.
// Optional range checking with a sticky error flag is enabled by defining XRAM_RANGE_CHK_EN.
module xram_resp #(
   parameter int ADDR_W      = 16,
   parameter int DEPTH       = 65536,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stb,
   input  logic              wr,
   input  logic [ADDR_W-1:0] addr,
   input  logic [7:0]        data_in,
   output logic [7:0]        data_out,
   output logic              ack,
   output logic [1:0]        xram_state,
   output logic              err,
   input  logic              err_clr
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      WAIT    = 2'b01,
      ACK     = 2'b10,
      ILLEGAL = 2'b11
   } state_t;

   state_t            state;
   logic [3:0]        count;
   logic [ADDR_W-1:0] addr_q;
   logic              wr_q;
   logic [7:0]        data_q;
   logic [7:0]        mem [DEPTH];

   logic [ADDR_W-1:0] acc_addr;
   logic              acc_wr;
   logic [7:0]        acc_data;
   logic [IDX_W-1:0]  idx;
   logic              do_access;
   logic              oob;
   logic              mem_we;
   logic [7:0]        rd_val;

   // With zero wait states the access happens on the acceptance edge, so the live request is used
   always_comb begin
      acc_addr = addr_q;
      acc_wr   = wr_q;
      acc_data = data_q;
      if (state == IDLE) begin
         acc_addr = addr;
         acc_wr   = wr;
         acc_data = data_in;
      end
   end

   assign idx       = acc_addr[IDX_W-1:0];
   assign do_access = stb && (((state == IDLE) && (WAIT_CYCLES == 0)) ||
                              ((state == WAIT) && (count == 4'd1)));

`ifdef XRAM_RANGE_CHK_EN
   assign oob = 32'(acc_addr) >= 32'(DEPTH);
`else
   assign oob = 1'b0;
   wire unused_ok = &{1'b0, err_clr, acc_addr};
`endif

   assign mem_we = do_access && acc_wr && !oob && !rst;

   always_comb begin
      rd_val = mem[idx];
      if (acc_wr)
         rd_val = acc_data;
      else if (oob)
         rd_val = 8'hFF;
   end

   // Storage has no reset so its contents survive a reset pulse
   always_ff @(posedge clk) begin
      if (mem_we)
         mem[idx] <= acc_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         count    <= 4'd0;
         ack      <= 1'b0;
         data_out <= 8'h00;
         addr_q   <= '0;
         wr_q     <= 1'b0;
         data_q   <= 8'h00;
      end else begin
         case (state)
            IDLE: begin
               ack <= 1'b0;
               if (stb) begin
                  addr_q <= addr;
                  wr_q   <= wr;
                  data_q <= data_in;
                  if (WAIT_CYCLES == 0) begin
                     state    <= ACK;
                     ack      <= 1'b1;
                     data_out <= rd_val;
                  end else begin
                     state <= WAIT;
                     count <= 4'(WAIT_CYCLES);
                  end
               end
            end
            WAIT: begin
               // A dropped strobe abandons the access before anything is committed
               if (!stb) begin
                  state <= IDLE;
                  count <= 4'd0;
               end else if (count == 4'd1) begin
                  state    <= ACK;
                  ack      <= 1'b1;
                  count    <= 4'd0;
                  data_out <= rd_val;
               end else begin
                  count <= count - 4'd1;
               end
            end
            ACK: begin
               state <= IDLE;
               ack   <= 1'b0;
            end
            default: begin
               state <= IDLE;
               ack   <= 1'b0;
               count <= 4'd0;
            end
         endcase
      end
   end

`ifdef XRAM_RANGE_CHK_EN
   // Clearing wins over a set on the same edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         err <= 1'b0;
      else if (err_clr)
         err <= 1'b0;
      else if (do_access && oob)
         err <= 1'b1;
   end
`else
   assign err = 1'b0;
`endif

   assign xram_state = state;

endmodule

// File: tb/tb_xram_resp.sv
// Self-checking bench for xram_resp: four instances cover WAIT_CYCLES 1/0/3 and a 256-byte DEPTH.
// Range-check expectations follow whether XRAM_RANGE_CHK_EN is defined.
module tb_xram_resp;

   typedef struct {
      logic [7:0] data;
      int         lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        stb     [4];
   logic        wr      [4];
   logic        err_clr [4];
   logic [15:0] addr    [4];
   logic [7:0]  din     [4];
   logic [7:0]  dout    [4];
   logic        ack     [4];
   logic        err     [4];
   logic [1:0]  st      [4];

   int   cyc    = 0;
   int   checks = 0;
   int   passed = 0;
   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   xram_resp #(.ADDR_W(16), .DEPTH(65536), .WAIT_CYCLES(1)) dut_w1 (
      .clk(clk), .rst(rst), .stb(stb[0]), .wr(wr[0]), .addr(addr[0]), .data_in(din[0]),
      .data_out(dout[0]), .ack(ack[0]), .xram_state(st[0]), .err(err[0]), .err_clr(err_clr[0]));
   xram_resp #(.ADDR_W(16), .DEPTH(65536), .WAIT_CYCLES(0)) dut_w0 (
      .clk(clk), .rst(rst), .stb(stb[1]), .wr(wr[1]), .addr(addr[1]), .data_in(din[1]),
      .data_out(dout[1]), .ack(ack[1]), .xram_state(st[1]), .err(err[1]), .err_clr(err_clr[1]));
   xram_resp #(.ADDR_W(16), .DEPTH(65536), .WAIT_CYCLES(3)) dut_w3 (
      .clk(clk), .rst(rst), .stb(stb[2]), .wr(wr[2]), .addr(addr[2]), .data_in(din[2]),
      .data_out(dout[2]), .ack(ack[2]), .xram_state(st[2]), .err(err[2]), .err_clr(err_clr[2]));
   xram_resp #(.ADDR_W(16), .DEPTH(256), .WAIT_CYCLES(1)) dut_d256 (
      .clk(clk), .rst(rst), .stb(stb[3]), .wr(wr[3]), .addr(addr[3]), .data_in(din[3]),
      .data_out(dout[3]), .ack(ack[3]), .xram_state(st[3]), .err(err[3]), .err_clr(err_clr[3]));

   // One isolated access; request fields are scrambled once accepted to show they are ignored
   task automatic drive(input int d, input logic w, input logic [15:0] a, input logic [7:0] wd,
                        output int start, output int ack_at, output logic [7:0] rd,
                        output logic ack_after);
      @(posedge clk); #1;
      stb[d]  = 1'b1;
      wr[d]   = w;
      addr[d] = a;
      din[d]  = wd;
      start   = cyc;
      ack_at  = -1;
      rd      = 8'hxx;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         if (ack[d]) begin
            ack_at = cyc;
            rd     = dout[d];
            break;
         end
         if (i >= 1) begin
            addr[d] = 16'($urandom);
            din[d]  = 8'($urandom);
            wr[d]   = ~w;
         end
      end
      @(posedge clk); #1;
      stb[d] = 1'b0;
      wr[d]  = 1'b0;
      @(negedge clk);
      ack_after = ack[d];
   endtask

   task automatic test_reset();
      for (int d = 0; d < 4; d++) begin
         checks++; if (ack[d] !== 1'b0) $display("[TB] FAIL reset_ack[%0d]: got %b want 0", d, ack[d]); else passed++;
         checks++; if (dout[d] !== 8'h00) $display("[TB] FAIL reset_data[%0d]: got %h want 00", d, dout[d]); else passed++;
         checks++; if (st[d] !== 2'b00) $display("[TB] FAIL reset_state[%0d]: got %b want 00", d, st[d]); else passed++;
         checks++; if (err[d] !== 1'b0) $display("[TB] FAIL reset_err[%0d]: got %b want 0", d, err[d]); else passed++;
      end
   endtask

   task automatic test_basic();
      int s, t; logic [7:0] rd; logic aa; exp_t e;
      sb.push_back('{8'hA5, 2});
      drive(0, 1'b1, 16'h0100, 8'hA5, s, t, rd, aa);
      e = sb.pop_front();
      checks++; if (t - s !== e.lat) $display("[TB] FAIL basic_wr_lat: got %0d want %0d", t - s, e.lat); else passed++;
      checks++; if (aa !== 1'b0) $display("[TB] FAIL basic_wr_ack_pulse: got %b want 0", aa); else passed++;
      sb.push_back('{8'hA5, 2});
      drive(0, 1'b0, 16'h0100, 8'h00, s, t, rd, aa);
      e = sb.pop_front();
      checks++; if (t - s !== e.lat) $display("[TB] FAIL basic_rd_lat: got %0d want %0d", t - s, e.lat); else passed++;
      checks++; if (rd !== e.data) $display("[TB] FAIL basic_rd_data: got %h want %h", rd, e.data); else passed++;
      checks++; if (aa !== 1'b0) $display("[TB] FAIL basic_rd_ack_pulse: got %b want 0", aa); else passed++;
   endtask

   task automatic test_back_to_back();
      int s, t, prev; logic [7:0] rd; logic aa; exp_t e;
      for (int i = 0; i < 4; i++) begin
         sb.push_back('{8'(8'h10 + i), 2});
         drive(0, 1'b1, 16'h0200 + 16'(i), 8'(8'h10 + i), s, t, rd, aa);
         e = sb.pop_front();
         checks++; if (rd !== e.data || t - s !== e.lat)
            $display("[TB] FAIL b2b_fill[%0d]: got %h/%0d want %h/%0d", i, rd, t - s, e.data, e.lat); else passed++;
      end
      for (int i = 0; i < 4; i++) sb.push_back('{8'(8'h10 + i), (i == 0) ? 2 : 3});
      @(posedge clk); #1;
      stb[0] = 1'b1; wr[0] = 1'b0; addr[0] = 16'h0200;
      prev = cyc;
      for (int i = 0; i < 4; i++) begin
         t = -1000; rd = 8'hxx;
         for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ack[0]) begin t = cyc; rd = dout[0]; break; end
         end
         e = sb.pop_front();
         checks++; if (t - prev !== e.lat) $display("[TB] FAIL b2b_spacing[%0d]: got %0d want %0d", i, t - prev, e.lat); else passed++;
         checks++; if (rd !== e.data) $display("[TB] FAIL b2b_data[%0d]: got %h want %h", i, rd, e.data); else passed++;
         prev = t;
         @(posedge clk); #1;
         if (i < 3) addr[0] = 16'h0200 + 16'(i + 1);
         else stb[0] = 1'b0;
      end
   endtask

   task automatic test_latency();
      int s, t; logic [7:0] rd; logic aa; exp_t e;
      sb.push_back('{8'h42, 1});
      drive(1, 1'b1, 16'h0040, 8'h42, s, t, rd, aa);
      sb.push_back('{8'h42, 1});
      drive(1, 1'b0, 16'h0040, 8'h00, s, t, rd, aa);
      e = sb.pop_front();
      e = sb.pop_front();
      checks++; if (t - s !== e.lat) $display("[TB] FAIL lat_w0: got %0d want %0d", t - s, e.lat); else passed++;
      checks++; if (rd !== e.data) $display("[TB] FAIL lat_w0_data: got %h want %h", rd, e.data); else passed++;
      checks++; if (aa !== 1'b0) $display("[TB] FAIL lat_w0_ack_pulse: got %b want 0", aa); else passed++;
      sb.push_back('{8'h77, 4});
      drive(2, 1'b1, 16'h0010, 8'h77, s, t, rd, aa);
      e = sb.pop_front();
      checks++; if (t - s !== e.lat) $display("[TB] FAIL lat_w3_wr: got %0d want %0d", t - s, e.lat); else passed++;
      sb.push_back('{8'h77, 4});
      drive(2, 1'b0, 16'h0010, 8'h00, s, t, rd, aa);
      e = sb.pop_front();
      checks++; if (t - s !== e.lat) $display("[TB] FAIL lat_w3_rd: got %0d want %0d", t - s, e.lat); else passed++;
      checks++; if (rd !== e.data) $display("[TB] FAIL lat_w3_data: got %h want %h", rd, e.data); else passed++;
   endtask

   task automatic test_abort();
      int s, t; logic [7:0] rd; logic aa, seen; exp_t e;
      @(posedge clk); #1;
      stb[2] = 1'b1; wr[2] = 1'b1; addr[2] = 16'h0010; din[2] = 8'h3C;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++; if (st[2] !== 2'b01) $display("[TB] FAIL abort_in_wait: got %b want 01", st[2]); else passed++;
      stb[2] = 1'b0;
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (ack[2]) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) $display("[TB] FAIL abort_no_ack: got %b want 0", seen); else passed++;
      checks++; if (dout[2] !== 8'h77) $display("[TB] FAIL abort_data_held: got %h want 77", dout[2]); else passed++;
      checks++; if (st[2] !== 2'b00) $display("[TB] FAIL abort_idle: got %b want 00", st[2]); else passed++;
      sb.push_back('{8'h77, 4});
      drive(2, 1'b0, 16'h0010, 8'h00, s, t, rd, aa);
      e = sb.pop_front();
      checks++; if (rd !== e.data) $display("[TB] FAIL abort_old_value: got %h want %h", rd, e.data); else passed++;
   endtask

   task automatic test_reset_mid();
      int s, t; logic [7:0] rd; logic aa; exp_t e;
      sb.push_back('{8'h11, 2});
      drive(0, 1'b1, 16'h0300, 8'h11, s, t, rd, aa);
      e = sb.pop_front();
      checks++; if (rd !== e.data) $display("[TB] FAIL rstmid_prefill: got %h want %h", rd, e.data); else passed++;
      @(posedge clk); #1;
      stb[0] = 1'b1; wr[0] = 1'b1; addr[0] = 16'h0300; din[0] = 8'h99;
      @(posedge clk); #1;
      checks++; if (st[0] !== 2'b01) $display("[TB] FAIL rstmid_in_wait: got %b want 01", st[0]); else passed++;
      rst = 1'b1;
      #1;
      checks++; if (ack[0] !== 1'b0) $display("[TB] FAIL rstmid_ack: got %b want 0", ack[0]); else passed++;
      checks++; if (dout[0] !== 8'h00) $display("[TB] FAIL rstmid_data: got %h want 00", dout[0]); else passed++;
      checks++; if (st[0] !== 2'b00) $display("[TB] FAIL rstmid_state: got %b want 00", st[0]); else passed++;
      #1;
      rst = 1'b0; stb[0] = 1'b0; wr[0] = 1'b0;
      sb.push_back('{8'h11, 2});
      drive(0, 1'b0, 16'h0300, 8'h00, s, t, rd, aa);
      e = sb.pop_front();
      checks++; if (rd !== e.data) $display("[TB] FAIL rstmid_byte_kept: got %h want %h", rd, e.data); else passed++;
      checks++; if (t - s !== e.lat) $display("[TB] FAIL rstmid_lat: got %0d want %0d", t - s, e.lat); else passed++;
   endtask

   task automatic test_range();
      int s, t; logic [7:0] rd; logic aa; exp_t e;
      sb.push_back('{8'h5A, 2});
      drive(3, 1'b1, 16'h0005, 8'h5A, s, t, rd, aa);
      e = sb.pop_front();
      checks++; if (rd !== e.data) $display("[TB] FAIL range_prefill: got %h want %h", rd, e.data); else passed++;
      sb.push_back('{8'hC3, 2});
      drive(3, 1'b1, 16'h0105, 8'hC3, s, t, rd, aa);
      e = sb.pop_front();
      checks++; if (t - s !== e.lat) $display("[TB] FAIL range_wr_lat: got %0d want %0d", t - s, e.lat); else passed++;
`ifdef XRAM_RANGE_CHK_EN
      checks++; if (err[3] !== 1'b1) $display("[TB] FAIL range_err_set: got %b want 1", err[3]); else passed++;
      sb.push_back('{8'h5A, 2});
      sb.push_back('{8'hFF, 2});
`else
      checks++; if (err[3] !== 1'b0) $display("[TB] FAIL range_err_tied: got %b want 0", err[3]); else passed++;
      sb.push_back('{8'hC3, 2});
      sb.push_back('{8'hC3, 2});
`endif
      drive(3, 1'b0, 16'h0005, 8'h00, s, t, rd, aa);
      e = sb.pop_front();
      checks++; if (rd !== e.data) $display("[TB] FAIL range_low_byte: got %h want %h", rd, e.data); else passed++;
      drive(3, 1'b0, 16'h0105, 8'h00, s, t, rd, aa);
      e = sb.pop_front();
      checks++; if (rd !== e.data) $display("[TB] FAIL range_high_read: got %h want %h", rd, e.data); else passed++;
`ifdef XRAM_RANGE_CHK_EN
      @(posedge clk); #1; err_clr[3] = 1'b1;
      @(posedge clk); #1; err_clr[3] = 1'b0;
      checks++; if (err[3] !== 1'b0) $display("[TB] FAIL range_err_clr: got %b want 0", err[3]); else passed++;
      err_clr[3] = 1'b1;
      drive(3, 1'b0, 16'h0180, 8'h00, s, t, rd, aa);
      err_clr[3] = 1'b0;
      checks++; if (err[3] !== 1'b0) $display("[TB] FAIL range_clr_priority: got %b want 0", err[3]); else passed++;
`endif
   endtask

   initial begin
      rst = 1'b1;
      for (int d = 0; d < 4; d++) begin
         stb[d] = 1'b0; wr[d] = 1'b0; err_clr[d] = 1'b0; addr[d] = 16'h0000; din[d] = 8'h00;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      test_reset();
      rst = 1'b0;
      test_basic();
      test_back_to_back();
      test_latency();
      test_abort();
      test_reset_mid();
      test_range();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
